// File: rtl/fibonacci_gen.sv
// Handshaked Fibonacci/Lucas term generator: one addition per clock, registered
// result with an exact overflow flag for any result width.
module fibonacci_gen #(
  parameter int unsigned N_W = 6,
  parameter int unsigned F_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic           lucas,
  output logic           busy,
  output logic           done,
  output logic [F_W-1:0] F,
  output logic           overflow
);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e         state_q, state_d;
  logic [F_W-1:0] a_q, a_d;
  logic [F_W-1:0] b_q, b_d;
  logic [F_W-1:0] f_q, f_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic           ovf_a_q, ovf_a_d;
  logic           ovf_b_q, ovf_b_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overflow_q, overflow_d;
  logic [F_W:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    f_d        = f_q;
    cnt_d      = cnt_q;
    ovf_a_d    = ovf_a_q;
    ovf_b_d    = ovf_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = lucas ? F_W'(2) : '0;
          b_d     = F_W'(1);
          cnt_d   = n;
          ovf_a_d = 1'b0;
          ovf_b_d = 1'b0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q != '0) begin
          a_d     = b_q;
          b_d     = sum[F_W-1:0];
          // Sticky: once a term exceeds the width, every later term does too.
          ovf_a_d = ovf_b_q;
          ovf_b_d = ovf_a_q | ovf_b_q | sum[F_W];
          cnt_d   = cnt_q - N_W'(1);
        end else begin
          f_d        = a_q;
          overflow_d = ovf_a_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      f_q        <= '0;
      cnt_q      <= '0;
      ovf_a_q    <= 1'b0;
      ovf_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      f_q        <= f_d;
      cnt_q      <= cnt_d;
      ovf_a_q    <= ovf_a_d;
      ovf_b_q    <= ovf_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign F        = f_q;
  assign overflow = overflow_q;

endmodule

// File: doc/fibonacci_gen.md
Name: fibonacci_gen

Overview:
- Parametrised, handshaked Fibonacci/Lucas term generator.
- Replaces the fixed 4-bit-index / 12-bit-result free-running Fibonacci block.
- Accepts an index n on a start strobe and iterates one addition per clock.
- Returns term n with a one-cycle done pulse and an exact overflow flag, so any width can be chosen without silently wrapping results.

Parameters:
- N_W, 6, width of index input n (max index 2^N_W-1)
- F_W, 32, width of result F and internal accumulators

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- n  input  N_W  term index, sampled with start
- lucas  input  1  mode, sampled with start: 0 = Fibonacci seeds (0,1), 1 = Lucas seeds (2,1)
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse, result valid
- F  output  F_W  term n, low F_W bits
- overflow  output  1  true value of term n exceeded 2^F_W-1

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, F=0, overflow=0; internal a, b, cnt, ovf_a, ovf_b cleared. rst has priority over all other inputs, including mid-CALC; an in-flight computation is discarded with no done.
- FSM states: IDLE, CALC.
- IDLE, start=1 at an edge:
  - a<=seed0 (0 or 2), b<=1, cnt<=n, ovf_a<=0, ovf_b<=0.
  - busy<=1; state<=CALC.
- IDLE, start=0: hold. done<=0 every edge except the one that completes.
- CALC, cnt!=0 at an edge:
  - a<=b; b<=(a+b) mod 2^F_W.
  - ovf_a<=ovf_b; ovf_b<=ovf_a|ovf_b|carry_out(a+b).
  - cnt<=cnt-1.
- CALC, cnt==0 at an edge:
  - F<=a; overflow<=ovf_a; done<=1; busy<=0; state<=IDLE.
- Latency: the start-sampling edge is edge 1; done and F update at edge n+2. busy is high from edge 1 up to, but not including, the edge n+2 update.
- overflow is exact. A wrap in b that is never shifted into a (the look-ahead term) does not flag.
- F and overflow hold their last value until the next done or rst.
- start while busy (state CALC) is ignored; n and lucas changes during CALC are ignored.
- start high in the cycle done is high: the state is already IDLE, so the request is accepted. Back-to-back throughput is one result per n+2 cycles.
- n=0 returns the seed0 value; n=1 returns 1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. rst held 2 cycles with start=1 -> busy=0, done=0, F=0, overflow=0 after release; no computation started.
2. Default params, n=10, lucas=0, start 1 cycle -> busy high 11 cycles; done pulses exactly once at edge 12; F=55, overflow=0.
3. Boundaries and mode:
   - n=0, lucas=0 -> F=0; n=1 -> F=1.
   - lucas=1, n=0 -> F=2; lucas=1, n=10 -> F=123.
   - Default params, n=47 -> F=2971215073, overflow=0.
   - n=48 -> F=512559680, overflow=1.
4. Instance N_W=5, F_W=12:
   - n=18 -> F=2584, overflow=0.
   - n=19 -> F=85, overflow=1.
   - n=18, lucas=1 (L18=5778) -> F=1682, overflow=1.
5. Handshake:
   - n=10 started, then start pulsed with n=3 at edge 5 -> single done at edge 12, F=55.
   - start held through done with n=3 -> second done 5 edges later, F=2.
6. rst asserted at edge 6 of an n=20 run -> busy=0, done never pulses, F=0.
   - Then n=5 start -> done at edge 7, F=5, overflow=0.
